// File: rtl/li_counter_checker_if.sv
// li_counter_checker_if: sample stream in, lock status and statistics out
interface li_counter_checker_if;
  logic        clear;
  logic        data_valid;
  logic [31:0] data_in;
  logic        locked;
  logic        error;
  logic [31:0] err_count;
  logic [31:0] sample_count;
  logic [15:0] wrap_count;
  logic [31:0] last_bad;
  logic [31:0] last_exp;
  modport master (output clear, data_valid, data_in,
                  input  locked, error, err_count, sample_count, wrap_count, last_bad, last_exp);
  modport slave  (input  clear, data_valid, data_in,
                  output locked, error, err_count, sample_count, wrap_count, last_bad, last_exp);
endinterface

// File: rtl/li_counter_checker.sv
// li_counter_checker: locks to a wrapping test count stream and keeps saturating error statistics
module li_counter_checker #(
  parameter int unsigned MAX_COUNT  = 65536,
  parameter bit          ALLOW_HOLD = 1'b1
) (
  input logic                 clk_in,
  input logic                 reset_n,
  li_counter_checker_if.slave bus
);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  localparam logic [31:0] MAX = 32'(MAX_COUNT);
  state_t      state_q;
  logic [31:0] exp_q, prev_q, err_count_q, sample_count_q, last_bad_q, last_exp_q;
  logic [15:0] wrap_count_q;
  logic        error_q;
  logic        in_range, match, hold, is_err, lk;
  logic [31:0] nxt;
  always_comb begin
    lk       = state_q == LOCKED;
    in_range = bus.data_in <= MAX;
    nxt      = bus.data_in == MAX ? 32'd0 : bus.data_in + 32'd1;
    match    = bus.data_in == exp_q;
    hold     = lk && !match && ALLOW_HOLD && bus.data_in == prev_q;
    is_err   = bus.data_valid && (lk ? !match && !hold : !in_range);
  end
  always_ff @(posedge clk_in) begin
    if (!reset_n || bus.clear) begin
      state_q        <= UNLOCKED;
      exp_q          <= '0;
      prev_q         <= '0;
      err_count_q    <= '0;
      sample_count_q <= '0;
      wrap_count_q   <= '0;
      last_bad_q     <= '0;
      last_exp_q     <= '0;
      error_q        <= 1'b0;
    end else begin
      error_q <= is_err;
      if (bus.data_valid) begin
        if (is_err) begin
          if (err_count_q != '1) err_count_q <= err_count_q + 32'd1;
          last_bad_q <= bus.data_in;
          last_exp_q <= lk ? exp_q : 32'd0;
        end
        if (lk && sample_count_q != '1) sample_count_q <= sample_count_q + 32'd1;
        if (lk && match && prev_q == MAX && bus.data_in == 32'd0 && wrap_count_q != '1)
          wrap_count_q <= wrap_count_q + 16'd1;
        // Accepted samples, initial lock and in-range errors all re-seed the sequence; holds leave it untouched
        if (in_range && !hold) begin
          state_q <= LOCKED;
          prev_q  <= bus.data_in;
          exp_q   <= nxt;
        end else if (!in_range) begin
          state_q <= UNLOCKED;
        end
      end
    end
  end
  assign bus.locked       = lk;
  assign bus.error        = error_q;
  assign bus.err_count    = err_count_q;
  assign bus.sample_count = sample_count_q;
  assign bus.wrap_count   = wrap_count_q;
  assign bus.last_bad     = last_bad_q;
  assign bus.last_exp     = last_exp_q;
endmodule

// File: tb/tb_li_counter_checker.sv
// tb_li_counter_checker: directed scoreboard bench over three parameterisations of the checker
module tb_li_counter_checker;
  typedef struct {
    int          sel;
    logic        err, lk;
    logic [31:0] ec, sc, wc, lb, le;
    string       nm;
  } exp_t;
  logic clk = 1'b0;
  logic [2:0] rn = 3'b111;
  logic issued = 1'b0;
  int checks = 0, failures = 0;
  exp_t q[$];
  li_counter_checker_if b0(), b1(), b2();
  li_counter_checker #(.MAX_COUNT(4),     .ALLOW_HOLD(1'b1)) u0 (.clk_in(clk), .reset_n(rn[0]), .bus(b0));
  li_counter_checker #(.MAX_COUNT(65536), .ALLOW_HOLD(1'b0)) u1 (.clk_in(clk), .reset_n(rn[1]), .bus(b1));
  li_counter_checker #(.MAX_COUNT(65536), .ALLOW_HOLD(1'b1)) u2 (.clk_in(clk), .reset_n(rn[2]), .bus(b2));
  always #5 clk = ~clk;
  task automatic idle_all();
    b0.clear = 0; b0.data_valid = 0; b0.data_in = 0;
    b1.clear = 0; b1.data_valid = 0; b1.data_in = 0;
    b2.clear = 0; b2.data_valid = 0; b2.data_in = 0;
    rn = 3'b111;
  endtask
  task automatic step(int s, bit r, bit c, bit v, logic [31:0] d, bit e_err, bit e_lk,
                      logic [31:0] ec, logic [31:0] sc, logic [31:0] wc, logic [31:0] lb, logic [31:0] le, string nm);
    exp_t e;
    @(negedge clk);
    idle_all();
    rn[s] = r;
    case (s)
      0: begin b0.clear = c; b0.data_valid = v; b0.data_in = d; end
      1: begin b1.clear = c; b1.data_valid = v; b1.data_in = d; end
      default: begin b2.clear = c; b2.data_valid = v; b2.data_in = d; end
    endcase
    e.sel = s; e.err = e_err; e.lk = e_lk; e.ec = ec; e.sc = sc; e.wc = wc; e.lb = lb; e.le = le; e.nm = nm;
    q.push_back(e);
    issued = 1'b1;
  endtask
  task automatic chk(string nm, string f, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s.%s got=%h want=%h", nm, f, a, e);
    end
  endtask
  initial begin
    exp_t e;
    logic [31:0] a_ec, a_sc, a_wc, a_lb, a_le;
    logic a_err, a_lk;
    forever begin
      @(posedge clk);
      if (issued) begin
        #1;
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_underflow got=0 want>0");
        end else begin
          e = q.pop_front();
          case (e.sel)
            0: begin a_err = b0.error; a_lk = b0.locked; a_ec = b0.err_count; a_sc = b0.sample_count;
                     a_wc = 32'(b0.wrap_count); a_lb = b0.last_bad; a_le = b0.last_exp; end
            1: begin a_err = b1.error; a_lk = b1.locked; a_ec = b1.err_count; a_sc = b1.sample_count;
                     a_wc = 32'(b1.wrap_count); a_lb = b1.last_bad; a_le = b1.last_exp; end
            default: begin a_err = b2.error; a_lk = b2.locked; a_ec = b2.err_count; a_sc = b2.sample_count;
                     a_wc = 32'(b2.wrap_count); a_lb = b2.last_bad; a_le = b2.last_exp; end
          endcase
          chk(e.nm, "error", 32'(a_err), 32'(e.err));
          chk(e.nm, "locked", 32'(a_lk), 32'(e.lk));
          chk(e.nm, "err_count", a_ec, e.ec);
          chk(e.nm, "sample_count", a_sc, e.sc);
          chk(e.nm, "wrap_count", a_wc, e.wc);
          chk(e.nm, "last_bad", a_lb, e.lb);
          chk(e.nm, "last_exp", a_le, e.le);
        end
      end
    end
  end
  initial begin
    idle_all();
    //   s r c v data   err lk ec sc wc lb le
    step(0,0,0,0,0,     0,0,0,0,0,0,0,"rst0");
    step(1,0,0,0,0,     0,0,0,0,0,0,0,"rst1");
    step(2,0,0,0,0,     0,0,0,0,0,0,0,"rst2");
    // lock and wrap, MAX_COUNT=4
    step(0,1,0,1,2,     0,1,0,0,0,0,0,"wrap_s2");
    step(0,1,0,1,3,     0,1,0,1,0,0,0,"wrap_s3");
    step(0,1,0,1,4,     0,1,0,2,0,0,0,"wrap_s4");
    step(0,1,0,1,0,     0,1,0,3,1,0,0,"wrap_s0a");
    step(0,1,0,1,1,     0,1,0,4,1,0,0,"wrap_s1");
    step(0,1,0,1,2,     0,1,0,5,1,0,0,"wrap_s2b");
    step(0,1,0,1,3,     0,1,0,6,1,0,0,"wrap_s3b");
    step(0,1,0,1,4,     0,1,0,7,1,0,0,"wrap_s4b");
    step(0,1,0,1,0,     0,1,0,8,2,0,0,"wrap_s0b");
    step(0,1,0,0,9,     0,1,0,8,2,0,0,"wrap_idle");
    // out-of-range drops lock
    step(0,0,0,1,1,     0,0,0,0,0,0,0,"oor_rst");
    step(0,1,0,1,3,     0,1,0,0,0,0,0,"oor_s3");
    step(0,1,0,1,9,     1,0,1,1,0,9,4,"oor_s9");
    step(0,1,0,1,1,     0,1,1,1,0,9,4,"oor_s1");
    step(0,1,0,1,2,     0,1,1,2,0,9,4,"oor_s2");
    step(0,1,1,1,3,     0,0,0,0,0,0,0,"clr0");
    step(0,1,0,1,1,     0,1,0,0,0,0,0,"clr0_s1");
    step(0,1,0,1,2,     0,1,0,1,0,0,0,"clr0_s2");
    // saturation: preload err_count just below the ceiling
    @(posedge clk);
    #2 u0.err_count_q = 32'hFFFF_FFFE;
    step(0,1,0,1,0,     1,1,32'hFFFF_FFFF,2,0,0,3,"sat_e1");
    step(0,1,0,1,3,     1,1,32'hFFFF_FFFF,3,0,3,1,"sat_e2");
    step(0,1,0,1,1,     1,1,32'hFFFF_FFFF,4,0,1,4,"sat_e3");
    step(0,1,0,0,0,     0,1,32'hFFFF_FFFF,4,0,1,4,"sat_idle");
    // skip error and re-sync, no hold
    step(1,1,0,1,10,    0,1,0,0,0,0,0,"skip_s10");
    step(1,1,0,1,11,    0,1,0,1,0,0,0,"skip_s11");
    step(1,1,0,1,13,    1,1,1,2,0,13,12,"skip_s13");
    step(1,1,0,1,14,    0,1,1,3,0,13,12,"skip_s14");
    step(1,0,0,0,0,     0,0,0,0,0,0,0,"hold0_rst");
    step(1,1,0,1,5,     0,1,0,0,0,0,0,"hold0_s5");
    step(1,1,0,1,5,     1,1,1,1,0,5,6,"hold0_s5b");
    step(1,1,0,1,6,     0,1,1,2,0,5,6,"hold0_s6");
    // hold allowed, then clear and reset mid-stream
    step(2,1,0,1,5,     0,1,0,0,0,0,0,"hold1_s5");
    step(2,1,0,1,5,     0,1,0,1,0,0,0,"hold1_s5b");
    step(2,1,0,1,6,     0,1,0,2,0,0,0,"hold1_s6");
    step(2,1,0,1,9,     1,1,1,3,0,9,7,"pre_clr_s9");
    step(2,1,1,1,100,   0,0,0,0,0,0,0,"clr2");
    step(2,1,0,1,7,     0,1,0,0,0,0,0,"clr2_s7");
    step(2,1,0,1,8,     0,1,0,1,0,0,0,"clr2_s8");
    step(2,0,1,1,50,    0,0,0,0,0,0,0,"rstclr2");
    step(2,1,0,1,7,     0,1,0,0,0,0,0,"rstclr2_s7");
    step(2,1,0,1,8,     0,1,0,1,0,0,0,"rstclr2_s8");
    @(negedge clk);
    idle_all();
    issued = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
